// File: rtl/prf_read_port_arbiter_pkg.sv
// Shared types and sizing for the banked PRF read-port arbiter.
// Banks are interleaved on the low bits of the physical register number.
package prf_read_port_arbiter_pkg;

   localparam int PR_COUNT           = 128;
   localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
   localparam int PRF_BANK_COUNT     = 4;
   localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
   localparam int PRF_RR_COUNT       = 11;
   localparam int LOG_PRF_RR_COUNT   = $clog2(PRF_RR_COUNT);
   localparam int XLEN               = 32;
   localparam int PRF_ROW_W          = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

   typedef logic [LOG_PR_COUNT-1:0]       pr_t;
   typedef logic [LOG_PRF_BANK_COUNT-1:0] prf_bank_t;
   typedef logic [LOG_PRF_RR_COUNT-1:0]   prf_rr_t;
   typedef logic [PRF_ROW_W-1:0]          prf_row_t;
   typedef logic [XLEN-1:0]               xlen_t;

   function automatic prf_rr_t rr_inc(input prf_rr_t idx);
      return (idx == prf_rr_t'(PRF_RR_COUNT-1)) ? '0 : idx + prf_rr_t'(1);
   endfunction

   function automatic prf_bank_t pr_bank(input pr_t pr);
      return pr[LOG_PRF_BANK_COUNT-1:0];
   endfunction

   function automatic prf_row_t pr_row(input pr_t pr);
      return pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
   endfunction

endpackage

// File: rtl/prf_bank_rr_picker.sv
// Round-robin picker for one PRF bank: first requester at or after ptr,
// wrapping from the last requester back to requester 0.
module prf_bank_rr_picker
   import prf_read_port_arbiter_pkg::*;
(
   input  logic [PRF_RR_COUNT-1:0] req_mask,
   input  prf_rr_t                 ptr,
   output logic [PRF_RR_COUNT-1:0] grant,
   output prf_rr_t                 winner,
   output logic                    any
);

   prf_rr_t idx;

   always_comb begin
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      idx    = ptr;
      for (int off = 0; off < PRF_RR_COUNT; off++) begin
         if (!any && req_mask[idx]) begin
            any    = 1'b1;
            winner = idx;
         end
         idx = rr_inc(idx);
      end
      if (any) begin
         grant[winner] = 1'b1;
      end
   end

endmodule

// File: rtl/prf_read_port_arbiter.sv
// Banked PRF read-port arbiter: per-bank round-robin grant, registered bank read, registered response.
// Optional PRF_ARB_SAME_PR_MERGE_EN also acks every requester asking for the winner's exact register.
module prf_read_port_arbiter
   import prf_read_port_arbiter_pkg::*;
(
   input  logic                                  CLK,
   input  logic                                  nRST,
   input  logic [PRF_RR_COUNT-1:0]               req_valid_by_rr,
   input  pr_t [PRF_RR_COUNT-1:0]                req_pr_by_rr,
   output logic [PRF_RR_COUNT-1:0]               req_ack_by_rr,
   output logic [PRF_BANK_COUNT-1:0]             bank_read_valid_by_bank,
   output prf_row_t [PRF_BANK_COUNT-1:0]         bank_read_upper_pr_by_bank,
   input  xlen_t [PRF_BANK_COUNT-1:0]            bank_rdata_by_bank,
   output logic [PRF_RR_COUNT-1:0]               resp_valid_by_rr,
   output xlen_t [PRF_RR_COUNT-1:0]              resp_data_by_rr
);

   logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0] req_mask;
   logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0] grant;
   logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0] ack_bank;
   prf_rr_t [PRF_BANK_COUNT-1:0]                winner;
   prf_rr_t [PRF_BANK_COUNT-1:0]                rr_ptr;
   logic [PRF_BANK_COUNT-1:0]                   any;
   pr_t [PRF_BANK_COUNT-1:0]                    win_pr;
   logic [PRF_RR_COUNT-1:0]                     ack_all;

   logic [PRF_BANK_COUNT-1:0]                   rd_vld_p1;
   prf_row_t [PRF_BANK_COUNT-1:0]               row_p1;
   logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0] dest_p1;

   logic [PRF_RR_COUNT-1:0]                     resp_vld_nxt;
   xlen_t [PRF_RR_COUNT-1:0]                    resp_data_nxt;
   logic [PRF_RR_COUNT-1:0]                     resp_vld_p2;
   xlen_t [PRF_RR_COUNT-1:0]                    resp_data_p2;

   always_comb begin
      req_mask = '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         for (int r = 0; r < PRF_RR_COUNT; r++) begin
            req_mask[b][r] = req_valid_by_rr[r] && (pr_bank(req_pr_by_rr[r]) == prf_bank_t'(b));
         end
      end
   end

   for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank
      prf_bank_rr_picker u_picker (
         .req_mask (req_mask[b]),
         .ptr      (rr_ptr[b]),
         .grant    (grant[b]),
         .winner   (winner[b]),
         .any      (any[b])
      );
   end

   always_comb begin
      win_pr   = '0;
      ack_bank = '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         win_pr[b] = req_pr_by_rr[winner[b]];
`ifdef PRF_ARB_SAME_PR_MERGE_EN
         for (int r = 0; r < PRF_RR_COUNT; r++) begin
            ack_bank[b][r] = any[b] && req_mask[b][r] && (req_pr_by_rr[r] == win_pr[b]);
         end
`else
         ack_bank[b] = grant[b];
`endif
      end
   end

   // Acks are suppressed while reset is held so no requester retires a request that will be dropped.
   always_comb begin
      ack_all = '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         ack_all = ack_all | ack_bank[b];
      end
      req_ack_by_rr = nRST ? ack_all : '0;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rr_ptr <= '0;
      end else begin
         for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            if (any[b]) begin
               rr_ptr[b] <= rr_inc(winner[b]);
            end
         end
      end
   end

   // Stage p1: bank read issued, destination requesters remembered per bank.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rd_vld_p1 <= '0;
         row_p1    <= '0;
         dest_p1   <= '0;
      end else begin
         rd_vld_p1 <= any;
         dest_p1   <= ack_bank;
         for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            if (any[b]) begin
               row_p1[b] <= pr_row(win_pr[b]);
            end
         end
      end
   end

   assign bank_read_valid_by_bank    = rd_vld_p1;
   assign bank_read_upper_pr_by_bank = row_p1;

   // A requester targets one bank per request, so at most one bank drives each response slot.
   always_comb begin
      resp_vld_nxt  = '0;
      resp_data_nxt = '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         for (int r = 0; r < PRF_RR_COUNT; r++) begin
            if (rd_vld_p1[b] && dest_p1[b][r]) begin
               resp_vld_nxt[r]  = 1'b1;
               resp_data_nxt[r] = bank_rdata_by_bank[b];
            end
         end
      end
   end

   // Stage p2: bank data returned to the requester(s).
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         resp_vld_p2  <= '0;
         resp_data_p2 <= '0;
      end else begin
         resp_vld_p2 <= resp_vld_nxt;
         for (int r = 0; r < PRF_RR_COUNT; r++) begin
            if (resp_vld_nxt[r]) begin
               resp_data_p2[r] <= resp_data_nxt[r];
            end
         end
      end
   end

   assign resp_valid_by_rr = resp_vld_p2;
   assign resp_data_by_rr  = resp_data_p2;

endmodule
